mem_line_bridge: RTL and testbench
==================================

MEM_LINE_BRIDGE -- requirements
Module: mem_line_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, giving the number of 32-bit words per cache line.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the byte address width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_req_i, input, mem_req_type (addr 32, data line LINE_WORDS*32, rw, valid): line request from cache_fsm.
REQ-006 SHALL have port mem_data_o, output, mem_data_type (data line LINE_WORDS*32, ready): line response to cache_fsm.
REQ-007 SHALL have port bus_req_o, output, 1 bit: word-bus request.
REQ-008 SHALL have port bus_we_o, output, 1 bit: word-bus write enable.
REQ-009 SHALL have port bus_addr_o, output, 32 bits: word-bus byte address.
REQ-010 SHALL have port bus_wdata_o, output, 32 bits: word-bus write data.
REQ-011 SHALL have port bus_gnt_i, input, 1 bit: bus accepted the current beat.
REQ-012 SHALL have port bus_rvalid_i, input, 1 bit: read data beat valid.
REQ-013 SHALL have port bus_rdata_i, input, 32 bits: read data.
REQ-014 SHALL have ports no_rd_o and no_wr_o, outputs, 32 bits each: completed line reads and line writes.

Function
REQ-015 SHALL implement FSM states IDLE, RD, WR, DONE, GAP.
REQ-016 In IDLE with mem_req_i.valid=1, SHALL latch base = addr with low log2(LINE_WORDS)+2 bits cleared, latch rw and the data line, clear the counters, and go to WR if rw=1, else RD.
REQ-017 In RD/WR, SHALL drive bus_req_o=1, bus_addr_o=base+4*issue_cnt and bus_we_o=rw until issue_cnt=LINE_WORDS.
REQ-018 In WR, SHALL drive bus_wdata_o with word issue_cnt, where word k is bits [32k+31:32k].
REQ-019 SHALL increment issue_cnt on each cycle in which bus_req_o and bus_gnt_i are both 1.
REQ-020 SHALL hold bus_req_o, bus_addr_o and bus_wdata_o stable while bus_gnt_i=0.
REQ-021 In RD, on bus_rvalid_i=1 SHALL store bus_rdata_i into word resp_cnt of the line buffer and increment resp_cnt.
REQ-022 In RD, a grant and an rvalid in the same cycle SHALL both be counted.
REQ-023 In RD, SHALL ignore rvalid once resp_cnt=LINE_WORDS.
REQ-024 RD SHALL go to DONE in the cycle after resp_cnt reaches LINE_WORDS.
REQ-025 WR SHALL go to DONE in the cycle after the LINE_WORDS-th grant; writes are posted and no response is awaited.
REQ-026 In DONE, SHALL assert mem_data_o.ready=1 for exactly one cycle, increment no_rd_o or no_wr_o, then go to GAP.
REQ-027 In GAP, SHALL ignore mem_req_i.valid for one cycle, then go to IDLE; this prevents re-issue while cache_fsm deasserts valid.
REQ-028 mem_data_o.data SHALL hold the last completed read line until the next read completes; it SHALL be unchanged by writes.
REQ-029 Changes to mem_req_i while not in IDLE SHALL be ignored; the latched request completes.
REQ-030 Minimum read latency with gnt=1 and rvalid one cycle after each grant SHALL be LINE_WORDS+2 cycles from request to ready.
REQ-031 Statistics counters SHALL wrap modulo 2^32.
REQ-032 bus_req_o SHALL be 0 in IDLE, DONE and GAP.

Reset
REQ-033 When rst_i=1 at a clock edge, the block SHALL enter IDLE.
REQ-034 On reset, SHALL clear all outputs: ready, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, mem_data_o.data, no_rd_o, no_wr_o.
REQ-035 Reset mid-burst SHALL abandon the transfer, and SHALL NOT assert ready.

Structure
REQ-036 mem_req_type, mem_data_type, LINE_WORDS and the FSM state enum SHALL live in package cache_def.
REQ-037 The block SHALL be a single module with no sub-modules; bus beat tracking uses inline counters of width log2(LINE_WORDS)+1.

Verification
REQ-038 Read with gnt=1 and rvalid one cycle later, addr 0x0000_1234 SHALL produce beats at 0x1230, 0x1234, 0x1238, 0x123C; ready on cycle 6; line word0..3 = rdata order; no_rd_o=1.
REQ-039 Write of line {0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA} at 0x40, with gnt low for 2 cycles per beat, SHALL hold address and data stable; beat order 0xAAAA@0x40 .. 0xDDDD@0x4C; ready once; no_wr_o=1.
REQ-040 valid held high 3 cycles after ready SHALL start exactly one new transfer, beginning after GAP.
REQ-041 rst_i asserted after the 2nd read beat SHALL drop bus_req_o next cycle, with no ready pulse, and counters at 0.
REQ-042 Simultaneous gnt and rvalid every cycle SHALL capture the line correctly; extra rvalid after 4 beats SHALL be ignored.

Source files
------------

// File: rtl/mem_line_bridge_pkg.sv
// Shared types for the cache line <-> word bus bridge.
// Line geometry, request/response bundles and the bridge FSM states.
package cache_def;

  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = LINE_WORDS * 32;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DONE,
    GAP
  } state_t;

endpackage

// File: rtl/mem_line_bridge_if.sv
// Single-word bus bundle seen between the bridge and the memory side.
// master drives beats, slave grants them and returns read data.
interface mem_line_bridge_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_line_bridge.sv
// Splits cache line requests into LINE_WORDS word-bus beats.
// Reads are reassembled into a line; writes are posted.
module mem_line_bridge #(
  parameter int LINE_WORDS = cache_def::LINE_WORDS,
  parameter int ADDR_W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  cache_def::mem_req_type  mem_req_i,
  output cache_def::mem_data_type mem_data_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [31:0]            bus_addr_o,
  output logic [31:0]            bus_wdata_o,
  input  logic                   bus_gnt_i,
  input  logic                   bus_rvalid_i,
  input  logic [31:0]            bus_rdata_i,
  output logic [31:0]            no_rd_o,
  output logic [31:0]            no_wr_o
);

  import cache_def::*;

  localparam int CW  = $clog2(LINE_WORDS) + 1;
  localparam int OFS = $clog2(LINE_WORDS) + 2;
  localparam int LW  = LINE_WORDS * 32;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic              r_rw;
  logic [LW-1:0]     r_wline;
  logic [LW-1:0]     r_rbuf;
  logic [LW-1:0]     r_rline;
  logic [CW-1:0]     r_issue;
  logic [CW-1:0]     r_resp;
  logic [31:0]       r_no_rd;
  logic [31:0]       r_no_wr;

  logic              w_busy;
  logic              w_req;
  logic              w_fire;
  logic              w_rcap;
  logic              w_accept;
  logic [CW-1:0]     w_issue_n;
  logic [CW-1:0]     w_resp_n;
  logic [LW-1:0]     w_rbuf_n;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  assign w_busy    = (r_state == RD) || (r_state == WR);
  assign w_req     = w_busy && (r_issue != LAST);
  assign w_fire    = w_req && bus_gnt_i;
  assign w_rcap    = (r_state == RD) && bus_rvalid_i
                   && (r_resp != LAST);
  assign w_accept  = (r_state == IDLE) && mem_req_i.valid;
  assign w_issue_n = r_issue + CW'(w_fire);
  assign w_resp_n  = r_resp + CW'(w_rcap);
  assign w_addr    = r_base + ADDR_W'({r_issue, 2'b00});
  assign w_unused  = ^mem_req_i.addr[OFS-1:0];

  // Last beat merges in the same cycle it arrives
  always_comb begin
    w_rbuf_n = r_rbuf;
    if (w_rcap) begin
      w_rbuf_n[32*r_resp[CW-2:0] +: 32] = bus_rdata_i;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (mem_req_i.valid) begin
          w_next = mem_req_i.rw ? WR : RD;
        end
      end
      RD: begin
        if (w_resp_n == LAST) w_next = DONE;
      end
      WR: begin
        if (w_issue_n == LAST) w_next = DONE;
      end
      DONE:    w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_rw    <= 1'b0;
      r_wline <= '0;
      r_rbuf  <= '0;
      r_rline <= '0;
      r_issue <= '0;
      r_resp  <= '0;
      r_no_rd <= '0;
      r_no_wr <= '0;
    end else begin
      r_state <= w_next;
      r_rbuf  <= w_rbuf_n;
      if (w_accept) begin
        r_base  <= {mem_req_i.addr[ADDR_W-1:OFS],
                    {OFS{1'b0}}};
        r_rw    <= mem_req_i.rw;
        r_wline <= mem_req_i.data;
        r_issue <= '0;
        r_resp  <= '0;
      end else begin
        r_issue <= w_issue_n;
        r_resp  <= w_resp_n;
      end
      if ((r_state == RD) && (w_next == DONE)) begin
        r_rline <= w_rbuf_n;
      end
      if (r_state == DONE) begin
        if (r_rw) r_no_wr <= r_no_wr + 32'd1;
        else      r_no_rd <= r_no_rd + 32'd1;
      end
    end
  end

  assign bus_req_o   = w_req;
  assign bus_we_o    = w_req && r_rw;
  assign bus_addr_o  = w_req ? 32'(w_addr) : '0;
  assign bus_wdata_o = (w_req && r_rw)
                     ? r_wline[32*r_issue[CW-2:0] +: 32]
                     : '0;

  assign mem_data_o.data  = r_rline;
  assign mem_data_o.ready = (r_state == DONE);
  assign no_rd_o          = r_no_rd;
  assign no_wr_o          = r_no_wr;

endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge: reads, stalled writes,
// back-to-back valid, overlapped grant/rvalid and mid-burst reset.
module tb_mem_line_bridge;

  logic                   clk = 1'b0;
  logic                   rst;
  cache_def::mem_req_type  req;
  cache_def::mem_data_type rsp;
  logic [31:0]            no_rd;
  logic [31:0]            no_wr;

  mem_line_bridge_if bus ();

  logic        auto_en;
  logic        rv_man;
  logic        rv_auto;
  logic [31:0] rd_man;
  logic [31:0] rd_auto;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus.rvalid = auto_en ? rv_auto : rv_man;
  assign bus.rdata  = auto_en ? rd_auto : rd_man;

  // Simple memory: answers each granted read one cycle later
  always @(posedge clk) begin
    rv_auto <= bus.req & bus.gnt;
    rd_auto <= 32'hD000_0000 | bus.addr;
  end

  mem_line_bridge #(
    .LINE_WORDS (4),
    .ADDR_W     (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_req_i    (req),
    .mem_data_o   (rsp),
    .bus_req_o    (bus.req),
    .bus_we_o     (bus.we),
    .bus_addr_o   (bus.addr),
    .bus_wdata_o  (bus.wdata),
    .bus_gnt_i    (bus.gnt),
    .bus_rvalid_i (bus.rvalid),
    .bus_rdata_i  (bus.rdata),
    .no_rd_o      (no_rd),
    .no_wr_o      (no_wr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] rw_a [4];
  logic [31:0] wv   [4];
  logic [31:0] xv   [4];
  int          lat;
  int          n;
  logic        got;

  initial begin
    rw_a = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    wv   = '{32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_CCCC, 32'h0000_DDDD};
    xv   = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
    rst     = 1'b1;
    req     = '0;
    bus.gnt = 1'b0;
    rv_man  = 1'b0;
    rd_man  = '0;
    auto_en = 1'b0;
    tick();
    tick();
    chk("rst_ready", rsp.ready, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_data", rsp.data, 0);
    chk("rst_no_rd", no_rd, 0);
    chk("rst_no_wr", no_wr, 0);
    rst = 1'b0;
    tick();

    // Read line at 0x1234: beats 0x1230..0x123C, ready on cycle 6
    req.valid = 1'b1;
    req.addr  = 32'h0000_1234;
    req.rw    = 1'b0;
    bus.gnt   = 1'b1;
    tick();
    req.valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rd_req", bus.req, (k < 4));
      chk("rd_addr", bus.addr, (k < 4) ? 32'h1230 + 4 * k : 0);
      chk("rd_we", bus.we, 0);
      chk("rd_rdy_early", rsp.ready, 0);
      rv_man = (k > 0);
      rd_man = (k > 0) ? rw_a[k-1] : 32'h0;
      tick();
    end
    rv_man = 1'b0;
    chk("rd_ready", rsp.ready, 1);
    chk("rd_line", rsp.data, {rw_a[3], rw_a[2], rw_a[1], rw_a[0]});
    chk("rd_req_done", bus.req, 0);
    tick();
    chk("rd_ready_once", rsp.ready, 0);
    chk("rd_no_rd", no_rd, 1);
    chk("rd_no_wr", no_wr, 0);
    tick();

    // Write line at 0x40 with two stall cycles per beat
    req.valid = 1'b1;
    req.rw    = 1'b1;
    req.addr  = 32'h0000_0040;
    req.data  = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    bus.gnt   = 1'b0;
    tick();
    req.valid = 1'b0;
    req.addr  = 32'hFFFF_FFF0;
    req.data  = '1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        chk("wr_req", bus.req, 1);
        chk("wr_we", bus.we, 1);
        chk("wr_addr", bus.addr, 32'h40 + 4 * k);
        chk("wr_wdata", bus.wdata, wv[k]);
        chk("wr_rdy_early", rsp.ready, 0);
        bus.gnt = (j == 2);
        tick();
      end
    end
    bus.gnt = 1'b0;
    chk("wr_ready", rsp.ready, 1);
    chk("wr_req_done", bus.req, 0);
    chk("wr_keep_line", rsp.data, {rw_a[3], rw_a[2], rw_a[1], rw_a[0]});
    tick();
    chk("wr_ready_once", rsp.ready, 0);
    chk("wr_no_wr", no_wr, 1);
    chk("wr_no_rd", no_rd, 1);
    tick();

    // valid held 3 cycles past ready: exactly one more read
    auto_en   = 1'b1;
    bus.gnt   = 1'b1;
    req.valid = 1'b1;
    req.rw    = 1'b0;
    req.addr  = 32'h0000_2008;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (rsp.ready) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("b2b_latency", lat, 6);
    tick();
    chk("b2b_gap_req", bus.req, 0);
    tick();
    chk("b2b_idle_req", bus.req, 0);
    tick();
    chk("b2b_restart_req", bus.req, 1);
    chk("b2b_restart_addr", bus.addr, 32'h2000);
    req.valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp.ready) n++;
    end
    chk("b2b_one_more", n, 1);
    chk("b2b_no_rd", no_rd, 3);
    chk("b2b_line", rsp.data, {32'hD000_200C, 32'hD000_2008,
                               32'hD000_2004, 32'hD000_2000});
    chk("b2b_idle_after", bus.req, 0);

    // Grant and rvalid together every cycle, plus one extra rvalid
    auto_en   = 1'b0;
    req.valid = 1'b1;
    req.addr  = 32'h0000_3000;
    tick();
    req.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("ov_rdy_early", rsp.ready, 0);
      chk("ov_addr", bus.addr, 32'h3000 + 4 * k);
      rv_man = 1'b1;
      rd_man = xv[k];
      tick();
    end
    rd_man = 32'hEEEE_EEEE;
    chk("ov_ready", rsp.ready, 1);
    chk("ov_line", rsp.data, {xv[3], xv[2], xv[1], xv[0]});
    tick();
    chk("ov_line_hold", rsp.data, {xv[3], xv[2], xv[1], xv[0]});
    chk("ov_no_rd", no_rd, 4);
    rv_man = 1'b0;
    tick();

    // Reset after the second read beat abandons the burst
    req.valid = 1'b1;
    req.addr  = 32'h0000_5000;
    tick();
    req.valid = 1'b0;
    tick();
    rv_man = 1'b1;
    rd_man = 32'h5555_0000;
    tick();
    chk("rr_req_before", bus.req, 1);
    rst = 1'b1;
    tick();
    chk("rr_req_drop", bus.req, 0);
    chk("rr_ready", rsp.ready, 0);
    chk("rr_no_rd", no_rd, 0);
    chk("rr_no_wr", no_wr, 0);
    chk("rr_data", rsp.data, 0);
    chk("rr_addr", bus.addr, 0);
    rst    = 1'b0;
    rv_man = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp.ready || bus.req) n++;
    end
    chk("rr_quiet", n, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
